capture_ctrl: RTL
=================

Name: capture_ctrl

Overview:
- Sequences the oscilloscope sample RAM (single port, synchronous write, asynchronous read) as a circular capture buffer.
- Accepts ADC samples, keeps a pre-trigger history and detects a level/edge trigger. Freezes after the post-trigger window fills.
- Streams the captured record oldest-first to the readout path through a valid/ready handshake.
- Sits between the ADC front end and the RAM instance, and owns every RAM control pin.

Parameters:
- DATA_WIDTH, 8, sample width; matches the RAM data width.
- ADDR_WIDTH, 8, RAM address width; record length N = 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- sample_in  in  DATA_WIDTH  ADC sample.
- sample_valid  in  1  sample_in is valid this cycle.
- arm  in  1  start a capture (pulse).
- abort  in  1  cancel any activity and return to IDLE.
- force_trig  in  1  forced-trigger request (pulse).
- trig_level  in  DATA_WIDTH  unsigned trigger threshold.
- trig_falling  in  1  0 = rising edge, 1 = falling edge.
- pre_count  in  ADDR_WIDTH  number of pre-trigger samples; latched on arm.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- ram_addr_in  out  ADDR_WIDTH  RAM write address.
- ram_addr_out  out  ADDR_WIDTH  RAM read address.
- ram_data_in  out  DATA_WIDTH  RAM write data.
- ram_data_out  in  DATA_WIDTH  RAM read data (async).
- rd_start  in  1  begin readout; honoured only in DONE.
- rd_data  out  DATA_WIDTH  readout sample.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts rd_data.
- rd_last  out  1  marks the final sample of the record.
- busy  out  1  state is not IDLE and not DONE.
- done  out  1  state is DONE.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. Pointers, counters, trig_addr, prev-sample register and prev_ok cleared. All outputs 0.
- States: IDLE, PREFILL, ARMED, POST, DONE, READ.
- Sample write (PREFILL, ARMED, POST): on sample_valid, ram_cs = ram_we = 1, ram_addr_in = wr_ptr, ram_data_in = sample_in, all combinational in the same cycle. wr_ptr then increments, wrapping mod N. ram_we is never high without sample_valid.
- IDLE: on arm, latch pc = pre_count, clear wr_ptr, clear prev_ok. Next state PREFILL if pc > 0, else ARMED.
- PREFILL: counts accepted samples. After the pc-th sample is written, move to ARMED. No trigger is evaluated in PREFILL, but the prev-sample register does update.
- ARMED: samples keep overwriting circularly.
  - Trigger on an accepted sample s when prev_ok and either rising (prev < trig_level <= s) or falling (prev > trig_level >= s), unsigned compare.
  - A force_trig pulse sets a sticky flag; the next accepted sample then triggers.
  - The trigger sample is written. trig_addr = its address. Next state POST with post_left = N - pc - 1.
  - If post_left = 0 (pc = N-1), go directly to DONE.
- prev_ok is set by the first accepted sample after arm. prev is updated on every accepted sample in PREFILL and ARMED.
- POST: each accepted sample decrements post_left. When the sample taken with post_left = 1 is written, next state is DONE. The record is exactly N samples including the trigger sample.
- DONE: ram_we = 0. On rd_start, rd_ptr = trig_addr - pc (mod N), rd_cnt = 0, next state READ. arm in DONE starts a new capture, same as from IDLE.
- READ:
  - ram_cs = ram_oe = 1, ram_addr_out = rd_ptr, rd_data = ram_data_out (combinational, zero latency), rd_valid = 1.
  - On rd_valid && rd_ready: rd_ptr++ (wraps), rd_cnt++.
  - rd_last = (rd_cnt == N-1). After that last transfer, next state IDLE.
  - rd_data is held stable while rd_ready is low.
- ram_oe = 0 outside READ. ram_cs = 0 in IDLE and DONE.
- arm outside IDLE/DONE is ignored. rd_start outside DONE is ignored.
- abort in any state: next state IDLE, sticky force flag cleared. abort has priority over arm, rd_start and triggers in the same cycle.
- rst_n low mid-capture or mid-readout: same result as the reset clause. The record is discarded.

Decomposition:
- Package osc_pkg holds:
  - typedef enum logic [2:0] cap_state_t {IDLE, PREFILL, ARMED, POST, DONE, READ}.
  - typedef enum logic {EDGE_RISING, EDGE_FALLING} trig_edge_t.
- Sub-module trigger_detect (parameter DATA_WIDTH) owns the prev-sample register, prev_ok, the sticky force flag and the edge compare. Its output trig_hit is qualified by sample_valid.

Test Plan (ADDR_WIDTH=4, N=16, DATA_WIDTH=8):
- Rising-trigger record:
  - Stimulus: pre_count=4, trig_level=0x80, rising; arm; ramp sample_in = 0x00, 0x10, ... one per cycle.
  - Required: trigger on 0x80 (prev 0x70); done after 11 further samples.
  - Readout: 16 beats 0x40..0x130 truncated to 8 bits (0x40, ..., 0xF0, 0x00, 0x10, 0x20, 0x30), rd_last on beat 16.
- Wrap-around:
  - Stimulus: pre_count=4; feed 40 samples below level, then one crossing sample.
  - Required: rd_data starts with the 4 samples immediately preceding the trigger sample; ram_addr_out wraps 15 -> 0 during readout.
- Force trigger, pre_count=0:
  - Stimulus: constant input 0x20, force_trig pulse after 3 samples.
  - Required: next sample triggers; trig_addr=3; readout starts at address 3.
- Backpressure:
  - Stimulus: rd_ready toggled 1,0,0,1.
  - Required: rd_data and ram_addr_out stay constant while rd_ready=0; exactly 16 transfers complete.
- Abort precedence:
  - Stimulus: abort asserted together with arm, then abort in POST.
  - Required: state IDLE next cycle; ram_we=0; a subsequent rd_start is ignored (rd_valid stays 0).
- Reset mid-readout:
  - Stimulus: drive rst_n low during READ.
  - Required: all outputs 0 at the next clk edge; state IDLE; done=0.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared types for the oscilloscope capture controller.
package osc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        ARMED,
        POST,
        DONE,
        READ
    } cap_state_t;

    typedef enum logic {
        EDGE_RISING,
        EDGE_FALLING
    } trig_edge_t;

endpackage

// File: rtl/trigger_detect.sv
// Level/edge trigger detector: previous-sample register, prev_ok qualifier,
// sticky forced-trigger flag and the unsigned threshold-crossing compare.
module trigger_detect
    import osc_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_track,
    input  logic                  i_eval,
    input  logic                  i_sample_valid,
    input  logic [DATA_WIDTH-1:0] i_sample,
    input  logic [DATA_WIDTH-1:0] i_trig_level,
    input  logic                  i_trig_falling,
    input  logic                  i_force_trig,
    output logic                  o_trig_hit
);

    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_prev_ok;
    logic                  r_force;
    logic                  w_accept;
    logic                  w_cross;

    assign w_accept = i_sample_valid & i_track;

    // Threshold crossing between the previous and the current sample.
    always_comb begin
        if (trig_edge_t'(i_trig_falling) == EDGE_FALLING)
            w_cross = (r_prev > i_trig_level) && (i_trig_level >= i_sample);
        else
            w_cross = (r_prev < i_trig_level) && (i_trig_level <= i_sample);
    end

    assign o_trig_hit = i_sample_valid & i_eval & (r_force | (r_prev_ok & w_cross));

    // History register and sticky force flag; a new arm forgets old history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev    <= '0;
            r_prev_ok <= 1'b0;
            r_force   <= 1'b0;
        end else if (i_clr) begin
            r_prev_ok <= 1'b0;
            r_force   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_prev    <= i_sample;
                r_prev_ok <= 1'b1;
            end
            if (o_trig_hit)
                r_force <= 1'b0;
            else if (i_force_trig && i_track)
                r_force <= 1'b1;
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Circular capture buffer sequencer for the oscilloscope sample RAM.
//
//  state   | meaning
//  IDLE    | no activity, waiting for arm
//  PREFILL | collecting the pre-trigger history, trigger not evaluated
//  ARMED   | overwriting circularly, waiting for a trigger
//  POST    | filling the post-trigger window
//  DONE    | record frozen, waiting for rd_start or a new arm
//  READ    | streaming the record oldest-first
module capture_ctrl
    import osc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  force_trig,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_falling,
    input  logic [ADDR_WIDTH-1:0] pre_count,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr_in,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    input  logic                  rd_start,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] L_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] L_LAST = '1;

    cap_state_t            r_state;
    cap_state_t            w_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_left;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_trig_addr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_cnt;
    logic                  w_capturing;
    logic                  w_wr;
    logic                  w_arm_go;
    logic                  w_rd_go;
    logic                  w_xfer;
    logic                  w_trig_hit;

    assign w_capturing = (r_state == PREFILL) || (r_state == ARMED) || (r_state == POST);
    assign w_wr        = w_capturing & sample_valid & ~abort;
    assign w_arm_go    = arm & ~abort & ((r_state == IDLE) || (r_state == DONE));
    assign w_rd_go     = (r_state == DONE) & rd_start & ~arm & ~abort;
    assign w_xfer      = (r_state == READ) & rd_ready & ~abort;

    trigger_detect #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_trig (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clr          (abort | w_arm_go),
        .i_track        ((r_state == PREFILL) || (r_state == ARMED)),
        .i_eval         (r_state == ARMED),
        .i_sample_valid (sample_valid),
        .i_sample       (sample_in),
        .i_trig_level   (trig_level),
        .i_trig_falling (trig_falling),
        .i_force_trig   (force_trig),
        .o_trig_hit     (w_trig_hit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; abort overrides every other request.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_arm_go) w_next = (pre_count != '0) ? PREFILL : ARMED;
                PREFILL: if (w_wr && r_left == L_ONE) w_next = ARMED;
                ARMED:   if (w_trig_hit) w_next = (r_pc == L_LAST) ? DONE : POST;
                POST:    if (w_wr && r_left == L_ONE) w_next = DONE;
                DONE: begin
                    if (w_arm_go)     w_next = (pre_count != '0) ? PREFILL : ARMED;
                    else if (w_rd_go) w_next = READ;
                end
                READ:    if (w_xfer && r_rd_cnt == L_LAST) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Pointers and down-counters; r_left counts pre-trigger then post-trigger samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_left      <= '0;
            r_wr_ptr    <= '0;
            r_trig_addr <= '0;
            r_rd_ptr    <= '0;
            r_rd_cnt    <= '0;
        end else begin
            if (w_arm_go) begin
                r_pc     <= pre_count;
                r_left   <= pre_count;
                r_wr_ptr <= '0;
            end
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + L_ONE;
            if (w_wr && (r_state == PREFILL || r_state == POST))
                r_left <= r_left - L_ONE;
            if (r_state == ARMED && w_trig_hit && !abort) begin
                r_trig_addr <= r_wr_ptr;
                r_left      <= ~r_pc;
            end
            if (w_rd_go) begin
                r_rd_ptr <= r_trig_addr - r_pc;
                r_rd_cnt <= '0;
            end
            if (w_xfer) begin
                r_rd_ptr <= r_rd_ptr + L_ONE;
                r_rd_cnt <= r_rd_cnt + L_ONE;
            end
        end
    end

    // RAM control and readout outputs decoded from the current state.
    always_comb begin
        ram_cs       = 1'b0;
        ram_we       = 1'b0;
        ram_oe       = 1'b0;
        ram_addr_in  = '0;
        ram_addr_out = '0;
        ram_data_in  = '0;
        rd_data      = '0;
        rd_valid     = 1'b0;
        rd_last      = 1'b0;
        busy         = (r_state != IDLE) && (r_state != DONE);
        done         = (r_state == DONE);
        if (w_wr) begin
            ram_cs      = 1'b1;
            ram_we      = 1'b1;
            ram_addr_in = r_wr_ptr;
            ram_data_in = sample_in;
        end
        if (r_state == READ) begin
            ram_cs       = 1'b1;
            ram_oe       = 1'b1;
            ram_addr_out = r_rd_ptr;
            rd_data      = ram_data_out;
            rd_valid     = 1'b1;
            rd_last      = (r_rd_cnt == L_LAST);
        end
    end

endmodule
